dmem_dma: RTL and testbench

// - Bus-initiator copy/fill engine for the single-cycle core's word-addressed data memory port (a, we, wd, rd).
// - The data memory has a combinational read and a posedge write.
// - Given a start pulse, the engine copies len words from src_addr to dst_addr, or fills len words at dst_addr with fill_val.
// - It owns the memory port while busy=1; top level muxes the core's port onto mem_* only when busy=0.

---
 rtl/dmem_dma_if.sv | 29 ++
 rtl/dmem_dma.sv | 152 +++++++++++++++
 tb/tb_dmem_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dma_if.sv
// Request/status handshake and data memory port of the copy/fill engine.
// The engine takes the master modport; the requester and memory sit on the slave side.
interface dmem_dma_if #(
    parameter int unsigned LEN_W = 16
) ();
    logic             start;
    logic             mode;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_val;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_a;
    logic             mem_we;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_val, mem_rd,
        output busy, done, err, mem_a, mem_we, mem_wd
    );

    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_val, mem_rd,
        input  busy, done, err, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/dmem_dma.sv
// Copy/fill engine that owns the word-addressed data memory port while busy.
// Copy takes a read and a write cycle per word; fill writes one word per cycle.
module dmem_dma #(
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned LEN_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    dmem_dma_if.master bus
);
    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRead,
        StWrite,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q;
    logic             rej_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      fill_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] rem_q;

    logic             busy, done, err, mem_we;
    logic [31:0]      mem_a, mem_wd;

    // End-of-range word indices, one bit wider than any address so nothing wraps.
    logic [32:0] src_end, dst_end;
    logic        reject;

    assign src_end = {3'b000, src_q[31:2]} + 33'(rem_q);
    assign dst_end = {3'b000, dst_q[31:2]} + 33'(rem_q);

    always_comb begin
        reject = 1'b0;
        if (dst_q[1:0] != 2'b00 || dst_end > 33'(MEM_WORDS)) begin
            reject = 1'b1;
        end
        if (!mode_q && (src_q[1:0] != 2'b00 || src_end > 33'(MEM_WORDS))) begin
            reject = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        mem_a   = 32'd0;
        mem_we  = 1'b0;
        mem_wd  = 32'd0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (reject || rem_q == '0) begin
                    state_d = StFinish;
                end else if (mode_q) begin
                    state_d = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
            StRead: begin
                mem_a   = src_q;
                state_d = StWrite;
            end
            StWrite: begin
                mem_a  = dst_q;
                mem_we = 1'b1;
                mem_wd = mode_q ? fill_q : buf_q;
                if (rem_q == LEN_W'(1)) begin
                    state_d = StFinish;
                end else if (mode_q) begin
                    state_d = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
            StFinish: begin
                done    = 1'b1;
                err     = rej_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request latch and transfer datapath; rem_q holds len until CHECK resolves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            rej_q  <= 1'b0;
            src_q  <= 32'd0;
            dst_q  <= 32'd0;
            fill_q <= 32'd0;
            buf_q  <= 32'd0;
            rem_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        rej_q  <= 1'b0;
                        src_q  <= bus.src_addr;
                        dst_q  <= bus.dst_addr;
                        fill_q <= bus.fill_val;
                        rem_q  <= bus.len;
                    end
                end
                StCheck: begin
                    rej_q <= reject;
                end
                StRead: begin
                    buf_q <= bus.mem_rd;
                end
                StWrite: begin
                    src_q <= src_q + 32'd4;
                    dst_q <= dst_q + 32'd4;
                    rem_q <= rem_q - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
    assign bus.mem_a  = mem_a;
    assign bus.mem_we = mem_we;
    assign bus.mem_wd = mem_wd;
endmodule

// File: tb/tb_dmem_dma.sv
// Randomised bench for dmem_dma: a transaction-level model predicts the per-cycle bus trace
// and final memory image, with directed cases pinning latency, counts and memory contents.
module tb_dmem_dma;
    localparam int unsigned MEM_WORDS = 512;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        we;
        logic        chk_wd;
        logic [31:0] a;
        logic [31:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    dmem_dma_if #(.LEN_W(16)) bus ();

    dmem_dma #(
        .MEM_WORDS(MEM_WORDS),
        .LEN_W    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem    [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    assign bus.mem_rd = dmem[bus.mem_a[10:2]];

    always @(posedge clk) begin
        if (bus.mem_we) dmem[bus.mem_a[10:2]] <= bus.mem_wd;
    end

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    exp_t exp_q[$];
    int   start_cyc, done_cyc, wecnt, done_cnt;
    bit   err_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input bit b, input bit dn, input bit er, input bit we,
                                input bit cw, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.busy = b; e.done = dn; e.err = er; e.we = we; e.chk_wd = cw; e.a = a; e.wd = wd;
        return e;
    endfunction

    // Per-cycle compare against the predicted trace; an empty queue means the port must be idle.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            bit   ok;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : mk(0, 0, 0, 0, 1, 32'd0, 32'd0);
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
                err_seen = bus.err;
            end
            if (bus.mem_we) wecnt++;
            ok = (bus.busy === e.busy) && (bus.done === e.done) && (bus.err === e.err) &&
                 (bus.mem_we === e.we) && (bus.mem_a === e.a) &&
                 (!e.chk_wd || bus.mem_wd === e.wd);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL trace: got busy=%b done=%b err=%b we=%b a=%h wd=%h want busy=%b done=%b err=%b we=%b a=%h wd=%h (cycle %0d)",
                         bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_a, bus.mem_wd,
                         e.busy, e.done, e.err, e.we, e.a, e.wd, cyc);
            end
        end
    end

    task automatic scramble_inputs();
        bus.mode     = 1'($urandom);
        bus.src_addr = $urandom;
        bus.dst_addr = $urandom;
        bus.len      = 16'($urandom);
        bus.fill_val = $urandom;
    endtask

    task automatic compare_mem(input string name);
        int diff = -1;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if (diff < 0 && dmem[i] !== ref_mem[i]) diff = i;
        end
        check(name, 64'(diff), 64'(-1));
    endtask

    // Issue one request; model applies sequential word-by-word semantics to ref_mem.
    task automatic run_req(input bit m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [31:0] f, input bit xs);
        exp_t    tr[$];
        bit      rej;
        longint  sw, dw;
        int      k;
        logic [31:0] v;
        sw  = longint'(s >> 2);
        dw  = longint'(d >> 2);
        rej = (d[1:0] != 2'b00) || (dw + longint'(n) > longint'(MEM_WORDS)) ||
              (!m && ((s[1:0] != 2'b00) || (sw + longint'(n) > longint'(MEM_WORDS))));
        tr.push_back(mk(0, 0, 0, 0, 1, 32'd0, 32'd0));
        tr.push_back(mk(1, 0, 0, 0, 1, 32'd0, 32'd0));
        if (!rej) begin
            for (int i = 0; i < int'(n); i++) begin
                if (!m) begin
                    tr.push_back(mk(1, 0, 0, 0, 0, s + 32'(4 * i), 32'd0));
                    v = ref_mem[int'(sw) + i];
                end else begin
                    v = f;
                end
                tr.push_back(mk(1, 0, 0, 1, 1, d + 32'(4 * i), v));
                ref_mem[int'(dw) + i] = v;
            end
        end
        tr.push_back(mk(1, 1, rej, 0, 1, 32'd0, 32'd0));

        @(posedge clk); #1;
        bus.mode = m; bus.src_addr = s; bus.dst_addr = d; bus.len = n; bus.fill_val = f;
        bus.start = 1'b1;
        foreach (tr[i]) exp_q.push_back(tr[i]);
        start_cyc = cyc; wecnt = 0; done_cnt = 0; err_seen = 0; done_cyc = -1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs();
        if (xs) begin
            k = $urandom_range(1, tr.size() - 1);
            repeat (k - 1) @(posedge clk);
            #1;
            bus.start = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check("trace_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk); #1;
        compare_mem("mem_image");
    endtask

    initial begin
        bus.start = 1'b0;
        scramble_inputs();
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done_err", 64'({bus.done, bus.err}), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_a_wd", {bus.mem_a, bus.mem_wd}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Copy A..D from 0x40 to 0x100.
        dmem[16] = 32'hA0A0_0001; dmem[17] = 32'hB0B0_0002;
        dmem[18] = 32'hC0C0_0003; dmem[19] = 32'hD0D0_0004;
        for (int i = 16; i < 20; i++) ref_mem[i] = dmem[i];
        run_req(0, 32'h40, 32'h100, 16'd4, 32'h0, 0);
        check("copy_latency", 64'(done_cyc - start_cyc), 64'd10);
        check("copy_we_cycles", 64'(wecnt), 64'd4);
        check("copy_w0", 64'(dmem[64]), 64'hA0A0_0001);
        check("copy_w3", 64'(dmem[67]), 64'hD0D0_0004);

        // Fill three words at 0x200; 0x20C must stay put.
        dmem[131] = 32'h1234_5678; ref_mem[131] = 32'h1234_5678;
        run_req(1, 32'h0, 32'h200, 16'd3, 32'hDEAD_BEEF, 0);
        check("fill_latency", 64'(done_cyc - start_cyc), 64'd5);
        check("fill_w2", 64'(dmem[130]), 64'hDEAD_BEEF);
        check("fill_untouched", 64'(dmem[131]), 64'h1234_5678);

        run_req(0, 32'h41, 32'h100, 16'd2, 32'h0, 0);
        check("rej_src_latency", 64'(done_cyc - start_cyc), 64'd2);
        check("rej_src_err_we", 64'({err_seen, 8'(wecnt)}), 64'h100);
        run_req(0, 32'h0, 32'h7FC, 16'd2, 32'h0, 0);
        check("rej_dst_err_we", 64'({err_seen, 8'(wecnt)}), 64'h100);
        run_req(1, 32'h0, 32'hFFFF_FFFC, 16'd1, 32'h5, 0);
        check("rej_wrap_err", 64'(err_seen), 64'd1);
        run_req(0, 32'h0, 32'h7F8, 16'd2, 32'h0, 0);
        check("edge_fit_err_we", 64'({err_seen, 8'(wecnt)}), 64'h002);

        run_req(0, 32'h10, 32'h20, 16'd0, 32'h0, 1);
        check("len0_latency", 64'(done_cyc - start_cyc), 64'd2);
        check("len0_done_cnt", 64'(done_cnt), 64'd1);
        check("len0_err", 64'(err_seen), 64'd0);

        for (int i = 0; i < 4; i++) begin
            dmem[i] = 32'(i + 1);
            ref_mem[i] = dmem[i];
        end
        run_req(0, 32'h0, 32'h4, 16'd3, 32'h0, 0);
        check("overlap_mem123", {dmem[1][15:0], dmem[2][15:0], dmem[3][15:0]}, 64'h0001_0001_0001);

        for (int r = 0; r < 40; r++) begin
            logic [31:0] s, d;
            s = 32'($urandom_range(0, 530)) * 4;
            d = 32'($urandom_range(0, 530)) * 4;
            if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
            run_req(1'($urandom), s, d, 16'($urandom_range(0, 10)), $urandom,
                    ($urandom_range(0, 2) == 0));
            check("rand_done_cnt", 64'(done_cnt), 64'd1);
        end

        // Reset asserted during the third write of an 8-word copy.
        chk_en = 1'b0;
        @(posedge clk); #1;
        bus.mode = 1'b0; bus.src_addr = 32'h300; bus.dst_addr = 32'h380; bus.len = 16'd8;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_w2_we_a", {31'd0, bus.mem_we, bus.mem_a}, {31'd0, 1'b1, 32'h388});
        check("mid_w2_wd", 64'(bus.mem_wd), 64'(ref_mem[194]));
        reset = 1'b0;
        #1;
        check("abort_busy_done_err_we", 64'({bus.busy, bus.done, bus.err, bus.mem_we}), 64'd0);
        check("abort_a_wd", {bus.mem_a, bus.mem_wd}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        ref_mem[224] = ref_mem[192];
        ref_mem[225] = ref_mem[193];
        compare_mem("abort_mem_image");
        chk_en = 1'b1;
        run_req(0, 32'h300, 32'h380, 16'd8, 32'h0, 0);
        check("after_abort_latency", 64'(done_cyc - start_cyc), 64'd18);
        check("after_abort_we_cycles", 64'(wecnt), 64'd8);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
